// File: rtl/s_axil_pkg.sv
// -----------------------------------------------------------------------------
// s_axil_pkg
//   Shared constants for the s_axil LFSR control block: register byte offsets
//   (as seen on address bits [4:0]), the AXI OKAY response code and the fixed
//   LFSR/data width.
// -----------------------------------------------------------------------------
package s_axil_pkg;

    localparam int DATA_W = 32;

    // Byte offsets within the register window. Only bits [4:2] take part in
    // decoding, so the low two bits of every offset are zero.
    localparam logic [4:0] REG_START = 5'h00;
    localparam logic [4:0] REG_STOP  = 5'h04;
    localparam logic [4:0] REG_SEED  = 5'h08;
    localparam logic [4:0] REG_TAPS  = 5'h0C;
    localparam logic [4:0] REG_LFSR  = 5'h10;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Turns a word index taken from addr[4:2] into a byte offset comparable
    // with the REG_* constants.
    function automatic logic [4:0] reg_offset(input logic [2:0] word_idx);
        return {word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/lfsr_galois32.sv
// -----------------------------------------------------------------------------
// lfsr_galois32
//   32-bit Galois LFSR with a synchronous parallel load.
//   Each step shifts left by one; when the bit shifted out (q[31]) is set the
//   tap mask is XORed into the shifted value.
//
//   Ports:
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous active-low reset, clears q
//     load     in   load load_val on the next edge (has priority over step)
//     load_val in   value to load
//     step     in   advance the LFSR by one position
//     taps     in   feedback tap mask
//     q        out  current LFSR value
// -----------------------------------------------------------------------------
module lfsr_galois32
    import s_axil_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              step,
    input  logic [DATA_W-1:0] taps,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] lfsr_q;
    logic [DATA_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (step) begin
            lfsr_d = {lfsr_q[DATA_W-2:0], 1'b0} ^ (lfsr_q[DATA_W-1] ? taps : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/s_axil.sv
// -----------------------------------------------------------------------------
// s_axil
//   AXI4-Lite slave with four control registers driving a programmable 32-bit
//   Galois LFSR whose value is streamed on an AXI4-Stream master port.
//
//   Register map (decoded on addr[4:2]):
//     0x00 start (RW)   0x04 stop (RW)   0x08 seed (RW)   0x0C taps (RW)
//     0x10 lfsr  (RO)   anything else reads 0, writes are dropped (OKAY)
//
//   Ports:
//     aclk, aresetn                 clock, asynchronous active-low reset
//     s_axi_aw* / s_axi_w* / s_axi_b*   AXI-Lite write address/data/response
//     s_axi_ar* / s_axi_r*          AXI-Lite read address/data
//     m_axis_tdata/tvalid/tready    LFSR output stream
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high; valid, once raised by this block, stays high with stable data
//   until that edge. AW and W are accepted together in one cycle only when
//   both are valid and the response slot is free or being drained.
// -----------------------------------------------------------------------------
module s_axil
    import s_axil_pkg::*;
#(
    parameter int C_AXIL_DATA_WIDTH = 32,  // only 32 is supported
    parameter int C_AXIL_ADDR_WIDTH = 32
) (
    input  logic                         aclk,
    input  logic                         aresetn,

    input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [C_AXIL_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,

    input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [C_AXIL_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,

    output logic [C_AXIL_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [C_AXIL_DATA_WIDTH-1:0] start_q, start_d;
    logic [C_AXIL_DATA_WIDTH-1:0] stop_q,  stop_d;
    logic [C_AXIL_DATA_WIDTH-1:0] seed_q,  seed_d;
    logic [C_AXIL_DATA_WIDTH-1:0] taps_q,  taps_d;
    logic                         bvalid_q, bvalid_d;
    logic                         rvalid_q, rvalid_d;
    logic [C_AXIL_DATA_WIDTH-1:0] rdata_q,  rdata_d;

    logic [C_AXIL_DATA_WIDTH-1:0] lfsr_val;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic       wr_accept;
    logic [4:0] wr_off;
    logic       seed_wr;

    // Ready is also gated by aresetn so that nothing looks acceptable while
    // the block is held in reset.
    assign wr_accept     = aresetn & s_axi_awvalid & s_axi_wvalid
                         & (~bvalid_q | s_axi_bready);
    assign s_axi_awready = wr_accept;
    assign s_axi_wready  = wr_accept;

    assign wr_off  = reg_offset(s_axi_awaddr[4:2]);
    assign seed_wr = wr_accept & (wr_off == REG_SEED);

    always_comb begin
        start_d = start_q;
        stop_d  = stop_q;
        seed_d  = seed_q;
        taps_d  = taps_q;
        if (wr_accept) begin
            case (wr_off)
                REG_START: start_d = s_axi_wdata;
                REG_STOP:  stop_d  = s_axi_wdata;
                REG_SEED:  seed_d  = s_axi_wdata;
                REG_TAPS:  taps_d  = s_axi_wdata;
                default:   ;  // read-only or unmapped: dropped, still OKAY
            endcase
        end
    end

    // A new accept re-arms the response slot even while the old one drains.
    always_comb begin
        bvalid_d = bvalid_q;
        if (wr_accept) begin
            bvalid_d = 1'b1;
        end else if (s_axi_bready) begin
            bvalid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic       rd_accept;
    logic [4:0] rd_off;

    assign s_axi_arready = aresetn & (~rvalid_q | s_axi_rready);
    assign rd_accept     = s_axi_arvalid & s_axi_arready;
    assign rd_off        = reg_offset(s_axi_araddr[4:2]);

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        if (rd_accept) begin
            rvalid_d = 1'b1;
            case (rd_off)
                REG_START: rdata_d = start_q;
                REG_STOP:  rdata_d = stop_q;
                REG_SEED:  rdata_d = seed_q;
                REG_TAPS:  rdata_d = taps_q;
                REG_LFSR:  rdata_d = lfsr_val;
                default:   rdata_d = '0;
            endcase
        end else if (s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // LFSR control
    // ------------------------------------------------------------------
    logic                         running;
    logic                         lfsr_load;
    logic [C_AXIL_DATA_WIDTH-1:0] lfsr_load_val;
    logic                         lfsr_step;

    // Stop dominates start; both come from registers so a write takes effect
    // one cycle after it is accepted.
    assign running = start_q[0] & ~stop_q[0];

    // While idle the LFSR keeps reloading the seed, so the first beat after
    // (re)starting is always the seed itself. A seed write wins over all.
    assign lfsr_load     = seed_wr | ~running;
    assign lfsr_load_val = seed_wr ? s_axi_wdata : seed_q;
    assign lfsr_step     = running & m_axis_tready;

    lfsr_galois32 u_lfsr (
        .clk      (aclk),
        .rst_n    (aresetn),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .step     (lfsr_step),
        .taps     (taps_q),
        .q        (lfsr_val)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            start_q  <= '0;
            stop_q   <= '0;
            seed_q   <= '0;
            taps_q   <= '0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            start_q  <= start_d;
            stop_q   <= stop_d;
            seed_q   <= seed_d;
            taps_q   <= taps_d;
            bvalid_q <= bvalid_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = RESP_OKAY;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;
    assign m_axis_tdata  = lfsr_val;
    assign m_axis_tvalid = running;

    // Address bits outside [4:2] do not take part in decoding.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[C_AXIL_ADDR_WIDTH-1:5], s_axi_awaddr[1:0],
                                s_axi_araddr[C_AXIL_ADDR_WIDTH-1:5], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_s_axil.sv
module tb_s_axil;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    // ---------------- clock ----------------
    always #5 aclk = ~aclk;

    s_axil #(
        .C_AXIL_DATA_WIDTH (32),
        .C_AXIL_ADDR_WIDTH (32)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    // ---------------- bookkeeping ----------------
    int n_total  = 0;
    int n_bad    = 0;
    int acc_stall = 0;
    int hs_b     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge aclk) begin
        if (aresetn && s_axi_bvalid && s_axi_bready) hs_b++;
    end

    // ---------------- reference model ----------------
    // Register file as an array indexed by word address 0..3, LFSR as a plain
    // value, channel valids as flags.
    logic [31:0] m_reg [0:3];
    logic [31:0] m_lfsr   = 32'h0;
    logic        m_bvalid = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata  = 32'h0;

    function automatic logic [31:0] galois(input logic [31:0] v, input logic [31:0] t);
        return (v << 1) ^ ((v >= 32'h8000_0000) ? t : 32'h0);
    endfunction

    function automatic logic [31:0] m_lookup(input logic [31:0] a);
        int idx;
        idx = int'(a[4:2]);
        if (idx < 4) return m_reg[idx];
        if (idx == 4) return m_lfsr;
        return 32'h0;
    endfunction

    function automatic logic m_running();
        return m_reg[0][0] && !m_reg[1][0];
    endfunction

    always @(posedge aclk) begin : model
        logic        run;
        logic        wacc;
        logic        racc;
        int          widx;
        logic [31:0] nl;
        if (!aresetn) begin
            for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
            m_lfsr   = 32'h0;
            m_bvalid = 1'b0;
            m_rvalid = 1'b0;
            m_rdata  = 32'h0;
        end else begin
            run  = m_running();
            wacc = s_axi_awvalid && s_axi_wvalid && (!m_bvalid || s_axi_bready);
            racc = s_axi_arvalid && (!m_rvalid || s_axi_rready);
            widx = int'(s_axi_awaddr[4:2]);
            if (wacc && widx == 2)            nl = s_axi_wdata;
            else if (!run)                    nl = m_reg[2];
            else if (m_axis_tready)           nl = galois(m_lfsr, m_reg[3]);
            else                              nl = m_lfsr;
            if (racc) m_rdata = m_lookup(s_axi_araddr);
            if (wacc && widx < 4) m_reg[widx] = s_axi_wdata;
            m_lfsr   = nl;
            m_bvalid = wacc || (m_bvalid && !s_axi_bready);
            m_rvalid = racc || (m_rvalid && !s_axi_rready);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge aclk) begin
        logic exp_wacc;
        logic exp_arrdy;
        if (aresetn) begin
            exp_wacc  = s_axi_awvalid && s_axi_wvalid && (!m_bvalid || s_axi_bready);
            exp_arrdy = !m_rvalid || s_axi_rready;
            check("awready", {31'b0, s_axi_awready}, {31'b0, exp_wacc});
            check("wready",  {31'b0, s_axi_wready},  {31'b0, exp_wacc});
            check("bvalid",  {31'b0, s_axi_bvalid},  {31'b0, m_bvalid});
            check("bresp",   {30'b0, s_axi_bresp},   32'h0);
            check("arready", {31'b0, s_axi_arready}, {31'b0, exp_arrdy});
            check("rvalid",  {31'b0, s_axi_rvalid},  {31'b0, m_rvalid});
            check("rresp",   {30'b0, s_axi_rresp},   32'h0);
            if (m_rvalid) check("rdata", s_axi_rdata, m_rdata);
            check("tvalid",  {31'b0, m_axis_tvalid}, {31'b0, m_running()});
            check("tdata",   m_axis_tdata, m_lfsr);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        logic acc;
        s_axi_awaddr  = a;
        s_axi_wdata   = d;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge aclk);
            acc = s_axi_awready && s_axi_wready;
            if (!acc) acc_stall++;
            tick();
        end
        check("write_accept", {31'b0, acc}, 32'h1);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
    endtask

    task automatic read(input logic [31:0] a, output logic [31:0] d);
        logic acc;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge aclk);
            acc = s_axi_arready;
            tick();
        end
        check("read_accept", {31'b0, acc}, 32'h1);
        s_axi_arvalid = 1'b0;
        @(negedge aclk);
        check("read_rvalid", {31'b0, s_axi_rvalid}, 32'h1);
        d = s_axi_rdata;
        tick();
    endtask

    task automatic read_expect(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        read(a, d);
        check(name, d, exp);
    endtask

    // Check tvalid/tdata on the next negedge, then move past the next edge.
    task automatic expect_beat(input string name, input logic v, input logic [31:0] exp);
        @(negedge aclk);
        check({name, "_tvalid"}, {31'b0, m_axis_tvalid}, {31'b0, v});
        check(name, m_axis_tdata, exp);
        tick();
    endtask

    // ---------------- directed stimulus ----------------
    logic [31:0] seq1 [0:3];
    int          hs_before;

    initial begin
        seq1[0] = 32'h0000_011D;
        seq1[1] = 32'h0000_023A;
        seq1[2] = 32'h0000_0474;
        seq1[3] = 32'h0000_08E8;

        aresetn       = 1'b0;
        s_axi_awaddr  = 32'h0;
        s_axi_wdata   = 32'h0;
        s_axi_araddr  = 32'h0;
        s_axi_awvalid = 1'b1;   // valid during reset must not be accepted
        s_axi_wvalid  = 1'b1;
        s_axi_arvalid = 1'b1;
        s_axi_bready  = 1'b1;
        s_axi_rready  = 1'b1;
        m_axis_tready = 1'b0;

        // Reset state
        #3;
        check("rst_awready", {31'b0, s_axi_awready}, 32'h0);
        check("rst_wready",  {31'b0, s_axi_wready},  32'h0);
        check("rst_bvalid",  {31'b0, s_axi_bvalid},  32'h0);
        check("rst_arready", {31'b0, s_axi_arready}, 32'h0);
        check("rst_rvalid",  {31'b0, s_axi_rvalid},  32'h0);
        check("rst_rdata",   s_axi_rdata,            32'h0);
        check("rst_tvalid",  {31'b0, m_axis_tvalid}, 32'h0);
        check("rst_tdata",   m_axis_tdata,           32'h0);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        @(posedge aclk);
        tick();
        aresetn = 1'b1;

        for (int i = 0; i < 5; i++) read_expect("rst_reg", 32'(i * 4), 32'h0);

        // Back-to-back configuration writes
        hs_before = hs_b;
        write(32'h08, 32'h0000_011D);
        write(32'h0C, 32'h0000_001D);
        write(32'h04, 32'h1);
        write(32'h00, 32'h1);
        tick();
        tick();
        check("b2b_bresp_count", 32'(hs_b - hs_before), 32'd4);
        check("b2b_stalls", 32'(acc_stall), 32'd0);

        m_axis_tready = 1'b1;
        read_expect("rd_seed",   32'h08, 32'h0000_011D);
        read_expect("rd_taps",   32'h0C, 32'h0000_001D);
        read_expect("rd_stop",   32'h04, 32'h1);
        read_expect("rd_start",  32'h00, 32'h1);
        read_expect("rd_seed_lowbits", 32'h0B, 32'h0000_011D);
        read_expect("rd_lfsr_idle",    32'h10, 32'h0000_011D);
        read_expect("rd_unmapped14",   32'h14, 32'h0);
        read_expect("rd_unmapped1c",   32'h1C, 32'h0);
        expect_beat("stopped", 1'b0, 32'h0000_011D);

        // Run: first beat is the seed
        write(32'h04, 32'h0);
        for (int i = 0; i < 4; i++) expect_beat("seq1", 1'b1, seq1[i]);

        // Backpressure: hold for three cycles
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) expect_beat("held", 1'b1, 32'h0000_11D0);
        m_axis_tready = 1'b1;
        expect_beat("resume0", 1'b1, 32'h0000_11D0);
        expect_beat("resume1", 1'b1, 32'h0000_23A0);
        write(32'h04, 32'h1);
        expect_beat("stop_edge", 1'b0, 32'h0000_8E80);
        expect_beat("stop_reload", 1'b0, 32'h0000_011D);

        // Feedback
        write(32'h08, 32'h8000_0000);
        write(32'h04, 32'h0);
        expect_beat("fb_a0", 1'b1, 32'h8000_0000);
        expect_beat("fb_a1", 1'b1, 32'h0000_001D);
        write(32'h04, 32'h1);
        write(32'h08, 32'hC000_0000);
        write(32'h04, 32'h0);
        expect_beat("fb_b0", 1'b1, 32'hC000_0000);
        expect_beat("fb_b1", 1'b1, 32'h8000_001D);
        expect_beat("fb_b2", 1'b1, 32'h0000_0027);

        // All-zero seed locks at zero
        write(32'h04, 32'h1);
        write(32'h08, 32'h0);
        write(32'h04, 32'h0);
        expect_beat("zero0", 1'b1, 32'h0);
        expect_beat("zero1", 1'b1, 32'h0);

        // Write response stall
        write(32'h04, 32'h1);
        tick();
        s_axi_bready = 1'b0;
        write(32'h0C, 32'h0000_002D);
        s_axi_awaddr  = 32'h14;
        s_axi_wdata   = 32'hDEAD_BEEF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            check("bstall_awready", {31'b0, s_axi_awready}, 32'h0);
            check("bstall_wready",  {31'b0, s_axi_wready},  32'h0);
            check("bstall_bvalid",  {31'b0, s_axi_bvalid},  32'h1);
            tick();
        end
        s_axi_bready = 1'b1;
        @(negedge aclk);
        check("bstall_release", {31'b0, s_axi_awready}, 32'h1);
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        @(negedge aclk);
        check("bstall_second_b", {31'b0, s_axi_bvalid}, 32'h1);
        tick();
        @(negedge aclk);
        check("bstall_drained", {31'b0, s_axi_bvalid}, 32'h0);
        tick();
        read_expect("rd_taps2",  32'h0C, 32'h0000_002D);
        read_expect("rd_seed_untouched", 32'h08, 32'h0);

        // Read data stall
        write(32'h08, 32'h1234_5678);
        s_axi_rready  = 1'b0;
        s_axi_araddr  = 32'h08;
        s_axi_arvalid = 1'b1;
        @(negedge aclk);
        check("rstall_first_ar", {31'b0, s_axi_arready}, 32'h1);
        tick();
        s_axi_araddr = 32'h0C;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            check("rstall_rvalid",  {31'b0, s_axi_rvalid},  32'h1);
            check("rstall_rdata",   s_axi_rdata,            32'h1234_5678);
            check("rstall_arready", {31'b0, s_axi_arready}, 32'h0);
            tick();
        end
        s_axi_rready = 1'b1;
        @(negedge aclk);
        check("rstall_release", {31'b0, s_axi_arready}, 32'h1);
        tick();
        s_axi_arvalid = 1'b0;
        @(negedge aclk);
        check("rstall_second_rvalid", {31'b0, s_axi_rvalid}, 32'h1);
        check("rstall_second_rdata",  s_axi_rdata,           32'h0000_002D);
        tick();
        @(negedge aclk);
        check("rstall_drained", {31'b0, s_axi_rvalid}, 32'h0);
        tick();

        // Reset while streaming
        write(32'h04, 32'h0);
        expect_beat("pre_reset", 1'b1, 32'h1234_5678);
        aresetn = 1'b0;
        #1;
        check("midrst_tvalid", {31'b0, m_axis_tvalid}, 32'h0);
        check("midrst_tdata",  m_axis_tdata,           32'h0);
        check("midrst_bvalid", {31'b0, s_axi_bvalid},  32'h0);
        check("midrst_rvalid", {31'b0, s_axi_rvalid},  32'h0);
        tick();
        aresetn = 1'b1;
        read_expect("midrst_start", 32'h00, 32'h0);
        read_expect("midrst_seed",  32'h08, 32'h0);
        expect_beat("midrst_idle", 1'b0, 32'h0);

        tick();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
